fft8_seq_ctrl: RTL and testbench
================================

Name: fft8_seq_ctrl

Overview:
- Phase sequencer for the 8-point radix-2 DIT FFT datapath.
- Drives the stage index counter (cnt4) through its data/load/en/lmt inputs and consumes the counter's out/tc outputs.
- Turns the counter value into sample-RAM addresses, butterfly pair addresses, twiddle indices and phase strobes for input load, three butterfly stages and output drain.

Parameters:
- N_LOG2, 3, log2 of FFT length; fixed at 3, other values unsupported.
- AW, 3, sample-RAM address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a transform; honoured only in IDLE
- in_valid  in  1  input sample present this cycle (LOAD only)
- out_ready  in  1  downstream accepts output sample (DRAIN only)
- cnt  in  3  counter value (counter out)
- tc  in  1  counter terminal count (out == lmt)
- cnt_data  out  3  counter load value; always 0
- cnt_load  out  1  counter synchronous load; has priority over cnt_en
- cnt_en  out  1  counter increment enable
- cnt_lmt  out  3  counter terminal value
- wr_en  out  1  input sample write strobe
- wr_addr  out  AW  bit-reversed write address
- bf_valid  out  1  butterfly issue strobe
- rd_addr_a  out  AW  butterfly top / drain read address
- rd_addr_b  out  AW  butterfly bottom address
- tw_idx  out  2  twiddle index k for W8^k
- stage  out  2  current stage 0..2 (0 outside STAGE)
- out_valid  out  1  drained sample valid
- busy  out  1  high in every state except IDLE
- done  out  1  registered one-cycle pulse at transform completion

Behaviour:
- Counter contract: cnt increments by 1 when cnt_en=1; loads cnt_data when cnt_load=1; tc=1 combinationally when cnt==cnt_lmt.
- Only state is registered (encoding IDLE, LOAD, STAGE0, STAGE1, STAGE2, DRAIN) plus done. All other outputs are combinational from state, cnt, tc and the handshake inputs.
- Reset: state=IDLE, done=0. With the IDLE decode this gives cnt_load=1, cnt_en=0, cnt_lmt=7, and wr_en, bf_valid, out_valid, busy all 0. Every address, tw_idx and stage output is 0.
- IDLE:
  - cnt_load=1, cnt_en=0, cnt_lmt=7, so the counter is parked at 0.
  - start=1 -> LOAD.
- LOAD:
  - cnt_lmt=7, cnt_en=in_valid, wr_en=in_valid.
  - wr_addr = {cnt[0],cnt[1],cnt[2]}.
  - in_valid && tc: cnt_load=1 (the counter returns to 0 on the same edge) -> STAGE0.
  - in_valid=0 stalls the phase indefinitely.
- STAGEs, s=0,1,2:
  - cnt_lmt=3, cnt_en=1, bf_valid=1, stage=s.
  - j=cnt[1:0], span=1<<s, pos=j&(span-1), grp=j>>s.
  - rd_addr_a = grp*2*span + pos; rd_addr_b = rd_addr_a + span; tw_idx = pos<<(2-s).
  - tc: cnt_load=1 -> next stage. From STAGE2 -> DRAIN with cnt_lmt=7.
  - The cnt_lmt change coincides with the load edge, so tc evaluates against the new limit from the first cycle of the new phase.
  - Each stage issues exactly 4 butterflies on consecutive cycles with no bubble.
- DRAIN:
  - cnt_lmt=7, rd_addr_a=cnt (natural order), out_valid=1, cnt_en=out_ready.
  - out_ready && tc: cnt_load=1, done<=1 for one cycle -> IDLE.
- Minimum latency from the start-accept edge: 8 (LOAD) + 12 (stages) + 8 (DRAIN) = 28 cycles until done is high.
- Boundary conditions:
  - start outside IDLE is ignored.
  - start held high in IDLE on the done cycle launches the next transform on the following cycle.
  - in_valid outside LOAD and out_ready outside DRAIN are ignored.
  - Reset asserted mid-phase forces IDLE immediately (asynchronously) and all strobes low; done is cleared.
  - tc with in_valid=0 in LOAD (or out_ready=0 in DRAIN) holds the state; it does not advance.

Test Plan:
- Reset then start, in_valid=1 for 8 cycles -> wr_addr sequence 0,4,2,6,1,5,3,7 with wr_en=1; STAGE0 entered on cycle 9 with cnt=0.
- STAGE0..2 run back-to-back -> (a,b,tw) are:
  - stage0: (0,1,0),(2,3,0),(4,5,0),(6,7,0)
  - stage1: (0,2,0),(1,3,2),(4,6,0),(5,7,2)
  - stage2: (0,4,0),(1,5,1),(2,6,2),(3,7,3)
  - bf_valid is high for exactly 12 cycles.
- DRAIN with out_ready toggling 1,0,1,... -> rd_addr_a steps 0..7 only on ready cycles; done pulses once after the 8th accepted sample; busy=0 the next cycle.
- in_valid gapped (1,0,0,1,...) during LOAD -> wr_addr advances only on valid cycles; no early transition to STAGE0.
- Reset asserted during STAGE1 at cnt=2 -> busy, bf_valid and done drop to 0 without waiting for a clock edge; cnt_load=1; a new start gives wr_addr=0 on the first LOAD cycle.
- start pulsed during STAGE2 -> ignored; exactly one done pulse per accepted start; start held high through done -> LOAD re-entered one cycle after done.

Source files
------------

// File: rtl/fft8_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft8_seq_ctrl_if
// Bundles the sequencer's handshake, counter and datapath-control signals.
//   slave  : the sequencer (fft8_seq_ctrl) side
//   master : the environment side (input source, output sink, stage counter)
// Signals:
//   start, in_valid, out_ready   - transform start and sample handshakes
//   cnt, tc                      - stage counter value and terminal count
//   cnt_data/load/en/lmt         - stage counter controls
//   wr_en, wr_addr               - bit-reversed input sample write
//   bf_valid, rd_addr_a/b, tw_idx, stage - butterfly issue
//   out_valid                    - drained sample valid (address on rd_addr_a)
//   busy, done                   - status
// ---------------------------------------------------------------------------
interface fft8_seq_ctrl_if #(
   parameter int AW = 3
);
   logic          start;
   logic          in_valid;
   logic          out_ready;
   logic [2:0]    cnt;
   logic          tc;
   logic [2:0]    cnt_data;
   logic          cnt_load;
   logic          cnt_en;
   logic [2:0]    cnt_lmt;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          bf_valid;
   logic [AW-1:0] rd_addr_a;
   logic [AW-1:0] rd_addr_b;
   logic [1:0]    tw_idx;
   logic [1:0]    stage;
   logic          out_valid;
   logic          busy;
   logic          done;

   modport slave (
      input  start, in_valid, out_ready, cnt, tc,
      output cnt_data, cnt_load, cnt_en, cnt_lmt,
             wr_en, wr_addr, bf_valid, rd_addr_a, rd_addr_b,
             tw_idx, stage, out_valid, busy, done
   );

   modport master (
      output start, in_valid, out_ready, cnt, tc,
      input  cnt_data, cnt_load, cnt_en, cnt_lmt,
             wr_en, wr_addr, bf_valid, rd_addr_a, rd_addr_b,
             tw_idx, stage, out_valid, busy, done
   );
endinterface

// File: rtl/fft8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fft8_seq_ctrl
// Phase sequencer for an 8-point radix-2 DIT FFT. Walks IDLE -> LOAD ->
// STAGE0 -> STAGE1 -> STAGE2 -> DRAIN -> IDLE, steering an external stage
// counter and decoding its value into RAM addresses, butterfly pairs,
// twiddle indices and phase strobes.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - fft8_seq_ctrl_if.slave (handshakes, counter control, datapath
//          control and status)
// Only the phase and the done pulse are registered; every other output is
// decoded combinationally from the phase, cnt, tc and the handshakes.
// ---------------------------------------------------------------------------
module fft8_seq_ctrl #(
   parameter int N_LOG2 = 3,
   parameter int AW     = 3
) (
   input  logic           clk,
   input  logic           rst,
   fft8_seq_ctrl_if.slave bus
);

   localparam int N = 1 << N_LOG2;

   // Counter limits: one per sample for LOAD/DRAIN, one per butterfly per stage.
   localparam logic [2:0] LMT_SAMPLES = 3'(N - 1);
   localparam logic [2:0] LMT_BFLY    = 3'(N / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STAGE0,
      STAGE1,
      STAGE2,
      DRAIN
   } state_t;

   state_t state_q, state_d;
   logic   done_q, done_d;

   logic [1:0]    j;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr_a;
   logic [AW-1:0] rd_addr_b;

   assign j = bus.cnt[1:0];

   always_comb begin
      // NOTE: every output gets a default before the case; any path that
      // forgot one would otherwise infer a latch.
      state_d      = state_q;
      done_d       = 1'b0;
      bus.cnt_load = 1'b0;
      bus.cnt_en   = 1'b0;
      bus.cnt_lmt  = LMT_SAMPLES;
      bus.wr_en    = 1'b0;
      bus.bf_valid = 1'b0;
      bus.tw_idx   = 2'd0;
      bus.stage    = 2'd0;
      bus.out_valid = 1'b0;
      bus.busy     = 1'b1;
      wr_addr      = '0;
      rd_addr_a    = '0;
      rd_addr_b    = '0;

      // The load on each phase exit returns the counter to 0 on the same edge
      // the phase (and hence cnt_lmt) changes, so tc is always judged against
      // the limit of the phase actually running.
      unique case (state_q)
         IDLE: begin
            bus.busy     = 1'b0;
            bus.cnt_load = 1'b1;   // park the counter at 0
            if (bus.start) state_d = LOAD;
         end

         LOAD: begin
            bus.cnt_en = bus.in_valid;
            bus.wr_en  = bus.in_valid;
            wr_addr    = {bus.cnt[0], bus.cnt[1], bus.cnt[2]};  // bit reversal
            if (bus.in_valid && bus.tc) begin
               bus.cnt_load = 1'b1;
               state_d      = STAGE0;
            end
         end

         // Butterfly pairs: span = 1<<s, pos = j & (span-1), grp = j >> s,
         // a = grp*2*span + pos, b = a + span, tw = pos << (2-s).
         // Each stage below is that formula with s substituted.
         STAGE0: begin
            bus.cnt_lmt  = LMT_BFLY;
            bus.cnt_en   = 1'b1;
            bus.bf_valid = 1'b1;
            bus.stage    = 2'd0;
            rd_addr_a    = {j, 1'b0};
            rd_addr_b    = {j, 1'b1};
            bus.tw_idx   = 2'd0;
            if (bus.tc) begin
               bus.cnt_load = 1'b1;
               state_d      = STAGE1;
            end
         end

         STAGE1: begin
            bus.cnt_lmt  = LMT_BFLY;
            bus.cnt_en   = 1'b1;
            bus.bf_valid = 1'b1;
            bus.stage    = 2'd1;
            rd_addr_a    = {j[1], 1'b0, j[0]};
            rd_addr_b    = {j[1], 1'b1, j[0]};
            bus.tw_idx   = {j[0], 1'b0};
            if (bus.tc) begin
               bus.cnt_load = 1'b1;
               state_d      = STAGE2;
            end
         end

         STAGE2: begin
            bus.cnt_lmt  = LMT_BFLY;
            bus.cnt_en   = 1'b1;
            bus.bf_valid = 1'b1;
            bus.stage    = 2'd2;
            rd_addr_a    = {1'b0, j};
            rd_addr_b    = {1'b1, j};
            bus.tw_idx   = j;
            if (bus.tc) begin
               bus.cnt_load = 1'b1;
               state_d      = DRAIN;
            end
         end

         DRAIN: begin
            bus.out_valid = 1'b1;
            bus.cnt_en    = bus.out_ready;
            rd_addr_a     = bus.cnt;   // natural order
            if (bus.out_ready && bus.tc) begin
               bus.cnt_load = 1'b1;
               done_d       = 1'b1;
               state_d      = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.cnt_data  = 3'd0;
   assign bus.wr_addr   = wr_addr;
   assign bus.rd_addr_a = rd_addr_a;
   assign bus.rd_addr_b = rd_addr_b;
   assign bus.done      = done_q;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft8_seq_ctrl
// Self-checking bench for fft8_seq_ctrl. A behavioural stage counter closes
// the cnt/tc loop. Each transform pushes its hand-computed write addresses,
// butterfly tuples, drain addresses and done pulse into queues; a negedge
// monitor pops and compares whenever the DUT raises wr_en, bf_valid,
// out_valid&&out_ready or done.
// ---------------------------------------------------------------------------
module tb_fft8_seq_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic cnt_rst;

   always #5 clk = ~clk;

   fft8_seq_ctrl_if #(.AW(3)) bus ();

   fft8_seq_ctrl #(.N_LOG2(3), .AW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Stage counter model: load beats enable, tc when value equals limit.
   logic [2:0] cnt_q;
   always_ff @(posedge clk or posedge cnt_rst) begin
      if (cnt_rst)           cnt_q <= 3'd0;
      else if (bus.cnt_load) cnt_q <= bus.cnt_data;
      else if (bus.cnt_en)   cnt_q <= cnt_q + 3'd1;
   end
   assign bus.cnt = cnt_q;
   assign bus.tc  = (cnt_q == bus.cnt_lmt);

   int tests = 0;
   int fails = 0;

   int wr_q[$];
   int bf_q[$];
   int dr_q[$];
   int done_q[$];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int pack(input int s, input int a, input int b, input int t);
      return (s << 8) | (a << 5) | (b << 2) | t;
   endfunction

   task automatic push_expect();
      int wr_exp[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      // {stage, a, b, tw}
      int bf_exp[12][4] = '{
         '{0, 0, 1, 0}, '{0, 2, 3, 0}, '{0, 4, 5, 0}, '{0, 6, 7, 0},
         '{1, 0, 2, 0}, '{1, 1, 3, 2}, '{1, 4, 6, 0}, '{1, 5, 7, 2},
         '{2, 0, 4, 0}, '{2, 1, 5, 1}, '{2, 2, 6, 2}, '{2, 3, 7, 3}
      };
      for (int i = 0; i < 8; i++) wr_q.push_back(wr_exp[i]);
      for (int i = 0; i < 12; i++)
         bf_q.push_back(pack(bf_exp[i][0], bf_exp[i][1], bf_exp[i][2], bf_exp[i][3]));
      for (int i = 0; i < 8; i++) dr_q.push_back(i);
      done_q.push_back(1);
   endtask

   // Monitor: compares DUT output events against the queued expectations.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.wr_en) begin
            check("wr_en_gated", int'(bus.in_valid), 1);
            check("wr_pending", int'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) check("wr_addr", int'(bus.wr_addr), wr_q.pop_front());
         end
         if (bus.bf_valid) begin
            check("bf_after_load", wr_q.size(), 0);
            check("bf_pending", int'(bf_q.size() != 0), 1);
            if (bf_q.size() != 0)
               check("bf_tuple",
                     pack(int'(bus.stage), int'(bus.rd_addr_a), int'(bus.rd_addr_b),
                          int'(bus.tw_idx)),
                     bf_q.pop_front());
         end
         if (bus.out_valid) begin
            if (bus.out_ready) begin
               check("drain_pending", int'(dr_q.size() != 0), 1);
               if (dr_q.size() != 0) check("drain_addr", int'(bus.rd_addr_a), dr_q.pop_front());
            end else if (dr_q.size() != 0) begin
               check("drain_hold", int'(bus.rd_addr_a), dr_q[0]);
            end
         end
         if (bus.done) begin
            check("done_pending", int'(done_q.size() != 0), 1);
            if (done_q.size() != 0) void'(done_q.pop_front());
         end
      end
   end

   task automatic drive(input int n, input int in_mode, input int out_mode,
                        input int pulse_cyc, input int keep_start);
      bus.in_valid  = (in_mode == 0)  ? 1'b1 : ((n % 3) == 1);
      bus.out_ready = (out_mode == 0) ? 1'b1 : ((n % 2) == 1);
      bus.start     = (keep_start != 0) || (n == pulse_cyc);
   endtask

   // Runs one transform starting just after its start-accept edge. Cycle 1
   // is the first LOAD cycle. Returns at the negedge of the done cycle, or
   // right after the reset when abort_cyc is reached.
   task automatic run_body(input int in_mode, input int out_mode, input int pulse_cyc,
                           input int abort_cyc, input int expect_lat, input int keep_start);
      bit seen = 1'b0;
      #1;
      drive(1, in_mode, out_mode, pulse_cyc, keep_start);
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            check("load_busy", int'(bus.busy), 1);
            check("load_cnt0", int'(bus.cnt), 0);
         end
         if (in_mode == 0 && cyc == 9) begin
            check("stage0_entry_bf", int'(bus.bf_valid), 1);
            check("stage0_entry_stage", int'(bus.stage), 0);
            check("stage0_entry_cnt", int'(bus.cnt), 0);
         end
         if (cyc == abort_cyc) begin
            check("abort_cnt", int'(bus.cnt), 2);
            check("abort_stage", int'(bus.stage), 1);
            #1 rst = 1'b1;
            #1;
            check("rst_busy", int'(bus.busy), 0);
            check("rst_bf_valid", int'(bus.bf_valid), 0);
            check("rst_done", int'(bus.done), 0);
            check("rst_cnt_load", int'(bus.cnt_load), 1);
            check("rst_wr_en", int'(bus.wr_en), 0);
            check("rst_out_valid", int'(bus.out_valid), 0);
            wr_q.delete();
            bf_q.delete();
            dr_q.delete();
            done_q.delete();
            @(posedge clk);
            #1;
            rst          = 1'b0;
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            return;
         end
         if (bus.done) begin
            check("done_idle", int'(bus.busy), 0);
            if (expect_lat > 0) check("latency", cyc - 1, expect_lat);
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         drive(cyc + 1, in_mode, out_mode, pulse_cyc, keep_start);
      end
      check("done_seen", int'(seen), 1);
   endtask

   task automatic launch();
      @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
   endtask

   initial begin
      rst           = 1'b1;
      cnt_rst       = 1'b1;
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      check("reset_cnt_load", int'(bus.cnt_load), 1);
      check("reset_cnt_en", int'(bus.cnt_en), 0);
      check("reset_cnt_lmt", int'(bus.cnt_lmt), 7);
      check("reset_cnt_data", int'(bus.cnt_data), 0);
      check("reset_wr_en", int'(bus.wr_en), 0);
      check("reset_bf_valid", int'(bus.bf_valid), 0);
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_addrs",
            int'({bus.wr_addr, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.stage}), 0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      cnt_rst = 1'b0;

      // Full-rate transform: latency and STAGE0 entry timing.
      push_expect();
      launch();
      run_body(0, 0, 0, 0, 28, 0);

      // Gapped input and toggling output ready.
      push_expect();
      launch();
      run_body(1, 1, 0, 0, 0, 0);

      // start pulsed during STAGE2 must be ignored.
      push_expect();
      launch();
      run_body(0, 0, 18, 0, 28, 0);

      // Reset during STAGE1 at cnt=2.
      push_expect();
      launch();
      run_body(0, 0, 0, 15, 0, 0);

      // Clean restart after reset, with start held high through done.
      push_expect();
      launch();
      run_body(0, 0, 0, 0, 28, 1);
      push_expect();
      @(posedge clk);
      run_body(0, 0, 0, 0, 28, 0);

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("end_idle", int'(bus.busy), 0);
      check("wr_q_empty", wr_q.size(), 0);
      check("bf_q_empty", bf_q.size(), 0);
      check("dr_q_empty", dr_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
